// File: rtl/div_mon_pkg.sv
// Shared types and default sizing for the divided-clock ratio monitor.
package div_mon_pkg;

  typedef enum logic [1:0] {IDLE, SEEK, MEAS} div_mon_state_t;

  localparam int DIV_MON_CNT_W    = 8;
  localparam int DIV_MON_LOCK_CNT = 4;

endpackage

// File: rtl/pow2_log2_enc.sv
// Combinational power-of-two detect and log2 encode of a measured period.
module pow2_log2_enc #(
  parameter int CNT_W = 8,
  parameter int LOG_W = $clog2(CNT_W)
) (
  input  logic [CNT_W-1:0] period,
  output logic             is_pow2,
  output logic [LOG_W-1:0] log2_ratio
);

  always_comb begin
    is_pow2    = (period != '0) && ((period & (period - 1'b1)) == '0) &&
                 (period != CNT_W'(1));
    log2_ratio = '0;
    // A ratio of 1 is not a divided clock, so bit 0 is never a valid log2.
    for (int i = 1; i < CNT_W; i++) begin
      if (period == (CNT_W'(1) << i)) log2_ratio = LOG_W'(i);
    end
  end

endmodule

// File: rtl/div_ratio_monitor.sv
// Measures period/high time of a clk-synchronous divided waveform, tracks lock,
// and flags ratio changes while locked and stuck inputs (counter overflow).
//
// state | meaning
// IDLE  | disabled or just reset; counters and outputs cleared
// SEEK  | waiting for the first rising edge to start a measurement
// MEAS  | counting cycles between rising edges
module div_ratio_monitor
  import div_mon_pkg::*;
#(
  parameter int CNT_W    = DIV_MON_CNT_W,
  parameter int LOCK_CNT = DIV_MON_LOCK_CNT,
  parameter int LOG_W    = $clog2(CNT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             duty50,
  output logic             is_pow2,
  output logic [LOG_W-1:0] log2_ratio,
  output logic             locked,
  output logic             err
);

  localparam logic [3:0] LOCK_M = 4'(LOCK_CNT);

  div_mon_state_t   state_q, state_d;
  logic             sig_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic             mv_q, mv_d, duty_q, duty_d, pow2_q, pow2_d;
  logic [LOG_W-1:0] log2_q, log2_d;
  logic             locked_q, locked_d, err_q, err_d;
  logic [3:0]       match_q, match_d;
  logic             rise, changed, enc_pow2;
  logic [LOG_W-1:0] enc_log2;

  pow2_log2_enc #(.CNT_W(CNT_W), .LOG_W(LOG_W)) u_enc (
    .period     (period_d),
    .is_pow2    (enc_pow2),
    .log2_ratio (enc_log2)
  );

  assign rise    = sig_in & ~sig_q;
  assign changed = locked_q && (cnt_q != period_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    period_d = period_q;
    high_d   = high_q;
    mv_d     = 1'b0;
    err_d    = 1'b0;
    duty_d   = duty_q;
    pow2_d   = pow2_q;
    log2_d   = log2_q;
    locked_d = locked_q;
    match_d  = match_q;
    if (!en) begin
      state_d  = IDLE;
      cnt_d    = '0;
      hcnt_d   = '0;
      period_d = '0;
      high_d   = '0;
      duty_d   = 1'b0;
      pow2_d   = 1'b0;
      log2_d   = '0;
      locked_d = 1'b0;
      match_d  = '0;
    end else begin
      case (state_q)
        IDLE: state_d = SEEK;
        SEEK: begin
          if (rise) begin
            cnt_d   = CNT_W'(1);
            hcnt_d  = CNT_W'(1);
            state_d = MEAS;
          end
        end
        MEAS: begin
          if (rise) begin
            period_d = cnt_q;
            high_d   = hcnt_q;
            mv_d     = 1'b1;
            duty_d   = ({hcnt_q, 1'b0} == {1'b0, cnt_q});
            pow2_d   = enc_pow2;
            log2_d   = enc_log2;
            // match_q==0 marks the first measurement after SEEK.
            if ((match_q != '0) && (cnt_q == period_q))
              match_d = (match_q >= LOCK_M) ? LOCK_M : match_q + 4'd1;
            else
              match_d = 4'd1;
            locked_d = (match_d == LOCK_M) && !changed;
            err_d    = changed;
            cnt_d    = CNT_W'(1);
            hcnt_d   = CNT_W'(1);
          end else if (cnt_q == '1) begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            match_d  = '0;
            cnt_d    = '0;
            hcnt_d   = '0;
            state_d  = SEEK;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            hcnt_d = hcnt_q + CNT_W'(sig_in);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sig_q    <= 1'b0;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      mv_q     <= 1'b0;
      duty_q   <= 1'b0;
      pow2_q   <= 1'b0;
      log2_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      match_q  <= '0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_in;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      mv_q     <= mv_d;
      duty_q   <= duty_d;
      pow2_q   <= pow2_d;
      log2_q   <= log2_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      match_q  <= match_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = mv_q;
  assign duty50     = duty_q;
  assign is_pow2    = pow2_q;
  assign log2_ratio = log2_q;
  assign locked     = locked_q;
  assign err        = err_q;

endmodule

// File: tb/tb_div_ratio_monitor.sv
// Directed bench for div_ratio_monitor: timestamp-based reference model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_div_ratio_monitor;

  localparam int CNT_W = 8;
  localparam int LOCK  = 4;
  localparam int LOG_W = 3;
  localparam int MAXC  = 255;

  logic             clk, rst, en, sig_in;
  logic [CNT_W-1:0] period, high_time;
  logic             meas_valid, duty50, is_pow2, locked, err;
  logic [LOG_W-1:0] log2_ratio;

  int checks = 0;
  int errors = 0;

  div_ratio_monitor #(.CNT_W(CNT_W), .LOCK_CNT(LOCK), .LOG_W(LOG_W)) dut (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .period(period), .high_time(high_time), .meas_valid(meas_valid),
    .duty50(duty50), .is_pow2(is_pow2), .log2_ratio(log2_ratio),
    .locked(locked), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: remembers every sampled sig_in value and the time of the
  // last rising edge, deriving period/high time from those timestamps.
  bit hist [0:8191];
  int t = 0;
  bit mdl_on = 0;
  bit prev_sig, active, armed;
  int t_last, match;
  int exp_period, exp_high, exp_log2;
  bit exp_mv, exp_duty, exp_pow2, exp_locked, exp_err;

  task automatic model_clear();
    exp_period = 0; exp_high = 0; exp_log2 = 0;
    exp_duty = 0; exp_pow2 = 0; exp_locked = 0;
    match = 0; active = 0; armed = 0;
  endtask

  task automatic model_step(input bit r, input bit e, input bit s);
    bit rise, chg;
    int p, h;
    exp_mv = 0; exp_err = 0;
    hist[t] = s;
    if (r) begin
      model_clear();
      prev_sig = 0;
    end else begin
      rise = s && !prev_sig;
      prev_sig = s;
      if (!e) model_clear();
      else if (!active) active = 1;
      else if (!armed) begin
        if (rise) begin armed = 1; t_last = t; end
      end else if (rise) begin
        p = t - t_last;
        h = 0;
        for (int k = t_last; k < t; k++) h += hist[k];
        chg = exp_locked && (p != exp_period);
        if (match > 0 && p == exp_period) match = (match + 1 > LOCK) ? LOCK : match + 1;
        else match = 1;
        exp_err = chg;
        exp_locked = (match == LOCK) && !chg;
        exp_period = p; exp_high = h; exp_mv = 1;
        exp_duty = (2 * h == p);
        exp_pow2 = 0; exp_log2 = 0;
        for (int k = 1; k < CNT_W; k++)
          if (p == (1 << k)) begin exp_pow2 = 1; exp_log2 = k; end
        t_last = t;
      end else if (t - t_last == MAXC) begin
        exp_err = 1; exp_locked = 0; match = 0; armed = 0;
      end
    end
    t++;
    mdl_on = 1;
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (mdl_on) begin
      chk("period", period, exp_period);
      chk("high_time", high_time, exp_high);
      chk("meas_valid", meas_valid, exp_mv);
      chk("duty50", duty50, exp_duty);
      chk("is_pow2", is_pow2, exp_pow2);
      chk("log2_ratio", log2_ratio, exp_log2);
      chk("locked", locked, exp_locked);
      chk("err", err, exp_err);
    end
  end

  task automatic cyc(input bit r, input bit e, input bit s);
    rst = r; en = e; sig_in = s;
    @(posedge clk);
    model_step(r, e, s);
    #1;
  endtask

  int ph;
  task automatic run_div(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      cyc(0, 1, (ph % (hi + lo)) < hi);
      ph++;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_high"}, high_time, 0);
    chk({tag, "_mv"}, meas_valid, 0);
    chk({tag, "_duty"}, duty50, 0);
    chk({tag, "_pow2"}, is_pow2, 0);
    chk({tag, "_log2"}, log2_ratio, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    rst = 1; en = 0; sig_in = 0;
    cyc(1, 0, 0); cyc(1, 0, 0);
    chk_zero("lit_reset");

    // divBy2: rise at 0 ignored (IDLE->SEEK), 2 seeds, 4 first measurement, 10 locks
    ph = 0; run_div(1, 1, 5);
    chk("lit_d2_period", period, 2); chk("lit_d2_high", high_time, 1);
    chk("lit_d2_duty", duty50, 1); chk("lit_d2_pow2", is_pow2, 1);
    chk("lit_d2_log2", log2_ratio, 1); chk("lit_d2_mv", meas_valid, 1);
    chk("lit_d2_unlocked", locked, 0);
    run_div(1, 1, 6);
    chk("lit_d2_locked", locked, 1); chk("lit_d2_err", err, 0);
    run_div(1, 1, 1);

    cyc(0, 0, 0);
    chk_zero("lit_en0_a");

    // divBy16: measurements at 32, 48, 64, 80
    ph = 0; run_div(8, 8, 33);
    chk("lit_d16_period", period, 16); chk("lit_d16_high", high_time, 8);
    chk("lit_d16_log2", log2_ratio, 4); chk("lit_d16_mv", meas_valid, 1);
    run_div(8, 8, 48);
    chk("lit_d16_locked", locked, 1);
    run_div(8, 8, 15);

    cyc(0, 0, 0);
    chk_zero("lit_en0_mid");

    // divBy4 to lock, then divBy8: err at first period 8, relock on 4th
    ph = 0; run_div(2, 2, 21);
    chk("lit_d4_locked", locked, 1);
    run_div(2, 2, 3);
    ph = 0; run_div(4, 4, 9);
    chk("lit_sw_err", err, 1); chk("lit_sw_unlocked", locked, 0);
    chk("lit_sw_period", period, 8);
    run_div(4, 4, 1);
    chk("lit_sw_err_once", err, 0);
    run_div(4, 4, 23);
    chk("lit_d8_relock", locked, 1);
    run_div(4, 4, 7);

    cyc(0, 0, 0);
    // odd 1,0,0 pattern
    ph = 0; run_div(1, 2, 7);
    chk("lit_d3_period", period, 3); chk("lit_d3_high", high_time, 1);
    chk("lit_d3_duty", duty50, 0); chk("lit_d3_pow2", is_pow2, 0);
    chk("lit_d3_log2", log2_ratio, 0);
    run_div(1, 2, 9);
    chk("lit_d3_locked", locked, 1);
    run_div(1, 2, 2);

    // stuck low after one rise: err 255 edges after that rise
    cyc(0, 1, 1);
    repeat (254) cyc(0, 1, 0);
    chk("lit_ovf_early", err, 0); chk("lit_ovf_still_locked", locked, 1);
    cyc(0, 1, 0);
    chk("lit_ovf_err", err, 1); chk("lit_ovf_unlock", locked, 0);
    chk("lit_ovf_period_kept", period, 3);
    repeat (44) cyc(0, 1, 0);
    cyc(0, 1, 1);
    chk("lit_reseek_no_mv", meas_valid, 0);
    cyc(0, 1, 0); cyc(0, 1, 0); cyc(0, 1, 1);
    chk("lit_reseek_mv", meas_valid, 1); chk("lit_reseek_period", period, 3);

    // lock on divBy2 then reset while locked
    ph = 0; run_div(1, 1, 11);
    chk("lit_pre_rst_locked", locked, 1);
    run_div(1, 1, 1);
    cyc(1, 1, 0);
    chk_zero("lit_rst_locked");
    cyc(0, 1, 0); cyc(0, 1, 1);
    chk("lit_post_rst_first", meas_valid, 0);
    cyc(0, 1, 0); cyc(0, 1, 1);
    chk("lit_post_rst_mv", meas_valid, 1); chk("lit_post_rst_period", period, 2);
    cyc(0, 1, 0); cyc(0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
